// File: rtl/enigma_rotor_stepper.sv
// Enigma rotor stepping controller: owns the three rotor positions and advances them
// once per keypress with odometer carry, notch turnover and the middle-rotor double-step.

module enigma_rotor_cell (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [4:0] load_val,
    input  logic       adv,
    output logic [4:0] pos,
    output logic       load_bad
);
    // Out-of-range start positions are replaced by 0 so pos never leaves 0..25.
    assign load_bad = load && (load_val > 5'd25);

    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= '0;
        end else if (load) begin
            pos <= load_bad ? 5'd0 : load_val;
        end else if (adv) begin
            pos <= (pos == 5'd25) ? 5'd0 : pos + 5'd1;
        end
    end
endmodule

module enigma_rotor_stepper #(
    parameter int unsigned NOTCH0 = 21,
    parameter int unsigned NOTCH1 = 4,
    parameter int unsigned NOTCH2 = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [4:0]       load_pos0,
    input  logic [4:0]       load_pos1,
    input  logic [4:0]       load_pos2,
    input  logic             step_req,
    input  logic             enc_done,
    output logic             step_ready,
    output logic             pos_valid,
    output logic [4:0]       pos0,
    output logic [4:0]       pos1,
    output logic [4:0]       pos2,
    output logic             load_err,
    output logic [CNT_W-1:0] char_count
);
    localparam int unsigned NUM_ROTORS = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // NOTCH2 carries no turnover today; kept in the table so a 4th rotor can reuse it.
    function automatic logic [4:0] notch_of(input int unsigned idx);
        case (idx)
            0:       notch_of = 5'(NOTCH0);
            1:       notch_of = 5'(NOTCH1);
            default: notch_of = 5'(NOTCH2);
        endcase
    endfunction

    state_t state_q, state_d;
    logic   do_load, do_step;
    logic   s1, s2;

    logic [NUM_ROTORS-1:0][4:0] load_vec;
    logic [NUM_ROTORS-1:0][4:0] pos_vec;
    logic [NUM_ROTORS-1:0]      adv_vec;
    logic [NUM_ROTORS-1:0]      bad_vec;

    assign load_vec = {load_pos2, load_pos1, load_pos0};

    // Carry decisions look only at pre-step positions; the middle rotor also
    // steps itself when sitting on its own notch (double-step).
    assign s1 = (pos_vec[0] == notch_of(0)) || (pos_vec[1] == notch_of(1));
    assign s2 = (pos_vec[1] == notch_of(1));

    assign adv_vec = {do_step & s2, do_step & s1, do_step};

    genvar r;
    generate
        for (r = 0; r < NUM_ROTORS; r++) begin : g_rotor
            enigma_rotor_cell u_cell (
                .clk      (clk),
                .rst      (rst),
                .load     (do_load),
                .load_val (load_vec[r]),
                .adv      (adv_vec[r]),
                .pos      (pos_vec[r]),
                .load_bad (bad_vec[r])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests arriving in HOLD are dropped, not queued.
    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        do_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    do_load = 1'b1;
                end else if (step_req) begin
                    do_step = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (enc_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            char_count <= '0;
            load_err   <= 1'b0;
        end else begin
            if (do_step) char_count <= char_count + 1'b1;
            if (|bad_vec) load_err <= 1'b1;
        end
    end

    assign step_ready = (state_q == IDLE);
    assign pos_valid  = (state_q == HOLD);
    assign pos0       = pos_vec[0];
    assign pos1       = pos_vec[1];
    assign pos2       = pos_vec[2];
endmodule

// File: tb/tb_enigma_rotor_stepper.sv
// Directed bench for enigma_rotor_stepper: load, stepping with double-step, wrap,
// handshake guards, load errors and reset mid-HOLD.

module tb_enigma_rotor_stepper;
    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [4:0]  load_pos0, load_pos1, load_pos2;
    logic        step_req;
    logic        enc_done;
    logic        step_ready;
    logic        pos_valid;
    logic [4:0]  pos0, pos1, pos2;
    logic        load_err;
    logic [15:0] char_count;

    int passed = 0;
    int total  = 0;

    enigma_rotor_stepper dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_pos0  (load_pos0),
        .load_pos1  (load_pos1),
        .load_pos2  (load_pos2),
        .step_req   (step_req),
        .enc_done   (enc_done),
        .step_ready (step_ready),
        .pos_valid  (pos_valid),
        .pos0       (pos0),
        .pos1       (pos1),
        .pos2       (pos2),
        .load_err   (load_err),
        .char_count (char_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Positions compared as one value {pos2,pos1,pos0}, 5 bits each.
    task automatic chk_pos(input string tag, input int p2, input int p1, input int p0);
        chk(tag, {17'd0, pos2, pos1, pos0}, {17'd0, 5'(p2), 5'(p1), 5'(p0)});
    endtask

    task automatic load(input int p2, input int p1, input int p0);
        load_en   = 1'b1;
        load_pos2 = 5'(p2);
        load_pos1 = 5'(p1);
        load_pos0 = 5'(p0);
        tick();
        load_en = 1'b0;
    endtask

    task automatic step_and_release(input string tag, input int p2, input int p1, input int p0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk_pos(tag, p2, p1, p0);
        chk({tag, "_valid"}, 32'(pos_valid), 32'd1);
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        chk({tag, "_ready"}, 32'(step_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; step_req = 1'b0; enc_done = 1'b0;
        load_pos0 = '0; load_pos1 = '0; load_pos2 = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk_pos("rst_pos", 0, 0, 0);
        chk("rst_ready", 32'(step_ready), 32'd1);
        chk("rst_valid", 32'(pos_valid), 32'd0);
        chk("rst_count", 32'(char_count), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);

        // ADU, single step to ADV
        load(0, 3, 20);
        chk_pos("load_adu", 0, 3, 20);
        chk("load_adu_valid", 32'(pos_valid), 32'd0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk_pos("step_adv", 0, 3, 21);
        chk("step_adv_valid", 32'(pos_valid), 32'd1);
        chk("step_adv_ready", 32'(step_ready), 32'd0);
        enc_done = 1'b1;
        tick();
        enc_done = 1'b0;
        chk("done_ready", 32'(step_ready), 32'd1);
        chk("done_valid", 32'(pos_valid), 32'd0);
        chk("done_count", 32'(char_count), 32'd1);

        // Double-step: AEW then BFX
        step_and_release("step_aew", 0, 4, 22);
        step_and_release("step_bfx", 1, 5, 23);
        chk("count3", 32'(char_count), 32'd3);

        // Wrap cases
        load(25, 25, 25);
        step_and_release("wrap_zza", 25, 25, 0);
        load(25, 4, 21);
        step_and_release("wrap_all", 0, 5, 22);
        chk("count5", 32'(char_count), 32'd5);

        // HOLD ignores step_req and load_en
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk_pos("hold_enter", 0, 5, 23);
        load_en = 1'b1; step_req = 1'b1;
        load_pos0 = 5'd7; load_pos1 = 5'd7; load_pos2 = 5'd7;
        tick();
        load_en = 1'b0; step_req = 1'b0;
        repeat (4) tick();
        chk_pos("hold_frozen", 0, 5, 23);
        chk("hold_valid", 32'(pos_valid), 32'd1);
        chk("hold_count", 32'(char_count), 32'd6);

        // enc_done with step_req in HOLD: only return to IDLE
        enc_done = 1'b1; step_req = 1'b1;
        tick();
        enc_done = 1'b0; step_req = 1'b0;
        chk("done_step_ready", 32'(step_ready), 32'd1);
        chk_pos("done_step_pos", 0, 5, 23);
        tick();
        chk("done_step_count", 32'(char_count), 32'd6);
        chk("done_step_idle", 32'(pos_valid), 32'd0);

        // load beats step in IDLE
        load_en = 1'b1; step_req = 1'b1;
        load_pos2 = 5'd1; load_pos1 = 5'd2; load_pos0 = 5'd3;
        tick();
        load_en = 1'b0; step_req = 1'b0;
        chk_pos("load_prio_pos", 1, 2, 3);
        chk("load_prio_ready", 32'(step_ready), 32'd1);
        chk("load_prio_count", 32'(char_count), 32'd6);
        chk("load_prio_err", 32'(load_err), 32'd0);

        // Out-of-range load, then reset mid-HOLD
        load(30, 2, 27);
        chk_pos("err_pos", 0, 2, 0);
        chk("err_flag", 32'(load_err), 32'd1);
        load(1, 1, 1);
        chk("err_sticky", 32'(load_err), 32'd1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk_pos("err_step", 1, 1, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_pos("midrst_pos", 0, 0, 0);
        chk("midrst_valid", 32'(pos_valid), 32'd0);
        chk("midrst_ready", 32'(step_ready), 32'd1);
        chk("midrst_count", 32'(char_count), 32'd0);
        chk("midrst_err", 32'(load_err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/enigma_rotor_stepper.md
Name: enigma_rotor_stepper

Overview:
- Stepping controller for the three-rotor Enigma datapath. It owns the rotor position registers and advances them once per keypress, using odometer rules with notch turnover and the middle-rotor double-step.
- Drives the `position` inputs of the forward and reverse rotor stages, rotor 0 being the fast rotor.
- Holds positions stable with a valid/done handshake while the downstream encode path finishes one character.

Parameters:
- NOTCH0, 21, fast-rotor turnover position (0..25). When rotor 0 sits here, the next step also advances rotor 1.
- NOTCH1, 4, middle-rotor turnover position (0..25). Used for middle-to-slow carry and for the double-step.
- NOTCH2, 16, slow-rotor notch (0..25). Unused for carry; exported for future 4th-rotor use.
- CNT_W, 16, width of the character counter.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- load_en, input, 1: load start positions (accepted only when step_ready=1).
- load_pos0, input, 5: start position for rotor 0 (fast).
- load_pos1, input, 5: start position for rotor 1 (middle).
- load_pos2, input, 5: start position for rotor 2 (slow).
- step_req, input, 1: single-cycle keypress request.
- enc_done, input, 1: downstream has consumed the character; releases positions.
- step_ready, output, 1: high when in IDLE.
- pos_valid, output, 1: positions are post-step and must be held by downstream.
- pos0, output, 5: rotor 0 position, 0..25.
- pos1, output, 5: rotor 1 position, 0..25.
- pos2, output, 5: rotor 2 position, 0..25.
- load_err, output, 1: sticky flag, set if any load_pos value exceeds 25.
- char_count, output, CNT_W: number of completed steps, wraps at 2^CNT_W.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values: pos0=pos1=pos2=0, pos_valid=0, step_ready=1, load_err=0, char_count=0, state IDLE.
- `rst` overrides everything in the same edge, including mid-HOLD. No output is retained.
- State machine, two states: IDLE and HOLD.
- IDLE with load_en=1:
  - Register load_posN into posN.
  - Any value >25 is replaced by 0 and sets load_err.
  - State stays IDLE.
  - load_en takes priority over a simultaneous step_req; the step is dropped and not queued.
- IDLE with step_req=1 (and load_en=0), at the sampling edge:
  - Stepping decision uses pre-step values only:
    - s1 = (pos0==NOTCH0) or (pos1==NOTCH1).
    - s2 = (pos1==NOTCH1).
  - pos0 <= pos0+1 mod 26 (always). pos1 steps if s1; pos2 steps if s2.
  - Increment is mod 26: 25 -> 0, never 26..31.
  - char_count++ on the same edge.
  - Go to HOLD: pos_valid=1 and step_ready=0 from the next cycle. Step latency is 1 clock.
- HOLD:
  - pos0..2 are frozen.
  - step_req and load_en are ignored; they are not buffered.
  - enc_done=1 -> IDLE next edge (pos_valid=0, step_ready=1).
  - enc_done in IDLE is ignored.
- enc_done and step_req together in HOLD: return to IDLE only. The new step_req is not taken.
- All outputs are registered; there are no combinational paths from input to output.
- load_err is cleared only by rst.

Test Plan:
- Reset then idle: assert rst 2 cycles, release -> pos=(0,0,0), step_ready=1, pos_valid=0, char_count=0.
- Load and single step:
  - Stimulus: load (pos2,pos1,pos0)=(0,3,20) ("ADU"), then step_req, then enc_done one cycle later.
  - Response: the cycle after the step shows pos=(0,3,21), pos_valid=1. The cycle after enc_done shows step_ready=1, char_count=1.
- Double-step sequence: from ADU with defaults, three step/enc_done pairs -> (0,3,21) ADV, (0,4,22) AEW, (1,5,23) BFX.
- Wrap: load (25,25,25) then step -> (25,25,0) (ZZA). Load (25,4,21) then step -> (0,5,22).
- Handshake guards:
  - Stimulus: in HOLD, pulse step_req and load_en with values (7,7,7); hold enc_done low 5 cycles.
  - Response: positions unchanged, pos_valid stays 1, char_count unchanged.
  - Also: in IDLE, load_en together with step_req loads and does not step.
- Error and reset mid-op:
  - Load (30,2,27) -> pos=(0,2,0), load_err=1.
  - Then step; while in HOLD assert rst -> next cycle all outputs at reset values, load_err=0.
